ones_pattern_gen: RTL and testbench

Sequential generator that builds a W-bit word containing exactly a requested number of ones, then rotates it left by a requested amount. It is the constructive inverse of the team's 64-bit ones counter: a count goes in and a word with that population comes out. The block feeds counter/decoder benches and test-pattern paths. Request and result use valid/ready handshakes. The build is serial, one bit or one rotate step per clock.

---
 rtl/ones_pattern_gen_if.sv | 28 ++
 rtl/ones_pattern_gen.sv | 118 +++++++++++
 tb/tb_ones_pattern_gen.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ones_pattern_gen_if.sv
// Request/result handshake bundle for ones_pattern_gen.
// The slave modport is the generator side; master is the requester/consumer.
interface ones_pattern_gen_if #(
    parameter int unsigned W  = 64,
    parameter int unsigned CW = 7,
    parameter int unsigned RW = 6
);
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_count;
    logic [RW-1:0] in_rot;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_word;
    logic          out_onehot;
    logic          out_onecold;
    logic          out_err;

    modport slave (
        input  in_valid, in_count, in_rot, out_ready,
        output in_ready, out_valid, out_word, out_onehot, out_onecold, out_err
    );

    modport master (
        output in_valid, in_count, in_rot, out_ready,
        input  in_ready, out_valid, out_word, out_onehot, out_onecold, out_err
    );
endinterface

// File: rtl/ones_pattern_gen.sv
// Serial generator of a W-bit word with a requested population, rotated left.
// Shifts in one '1' per clock, then rotates one step per clock.
module ones_pattern_gen #(
    parameter int unsigned W  = 64,
    parameter int unsigned CW = 7,
    parameter int unsigned RW = 6
) (
    input  logic               clk,
    input  logic               rst,
    ones_pattern_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUILD  = 2'd1,
        ROTATE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  word_q, word_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] rot_q, rot_d;
    logic          err_q, err_d;
    logic          onehot_q, onehot_d;
    logic          onecold_q, onecold_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          req_err;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            word_q      <= '0;
            cnt_q       <= '0;
            rot_q       <= '0;
            err_q       <= 1'b0;
            onehot_q    <= 1'b0;
            onecold_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            cnt_q       <= cnt_d;
            rot_q       <= rot_d;
            err_q       <= err_d;
            onehot_q    <= onehot_d;
            onecold_q   <= onecold_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign req_err = (bus.in_count > CW'(W));

    // Next-state and next-register logic
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        cnt_d     = cnt_q;
        rot_d     = rot_q;
        err_d     = err_q;
        onehot_d  = onehot_q;
        onecold_d = onecold_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    word_d    = '0;
                    cnt_d     = req_err ? '0 : bus.in_count;
                    rot_d     = req_err ? '0 : bus.in_rot;
                    err_d     = req_err;
                    onehot_d  = !req_err && (bus.in_count == CW'(1));
                    onecold_d = !req_err && (bus.in_count == CW'(W - 1));
                    if (req_err)
                        state_d = DONE;
                    else if (bus.in_count != '0)
                        state_d = BUILD;
                    else if (bus.in_rot != '0)
                        state_d = ROTATE;
                    else
                        state_d = DONE;
                end
            end
            BUILD: begin
                word_d = {word_q[W-2:0], 1'b1};
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1))
                    state_d = (rot_q != '0) ? ROTATE : DONE;
            end
            ROTATE: begin
                word_d = {word_q[W-2:0], word_q[W-1]};
                rot_d  = rot_q - RW'(1);
                if (rot_q == RW'(1))
                    state_d = DONE;
            end
            DONE: begin
                if (out_valid_q && bus.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // The result is presented one edge after entering DONE
        out_valid_d = (state_q == DONE) && (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_word    = word_q;
    assign bus.out_onehot  = onehot_q;
    assign bus.out_onecold = onecold_q;
    assign bus.out_err     = err_q;

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Scoreboard bench for ones_pattern_gen: driver pushes expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_ones_pattern_gen;

    localparam int unsigned W  = 64;
    localparam int unsigned CW = 7;
    localparam int unsigned RW = 6;

    typedef struct {
        logic [63:0] word;
        bit          oh;
        bit          oc;
        bit          err;
        int          cnt;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        int          c;
        int          r;
        int          hold;
        logic [63:0] word;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t sb[$];
    int   hold_req  = 0;
    bit   rand_stall = 1'b0;

    ones_pattern_gen_if #(.W(W), .CW(CW), .RW(RW)) bus ();

    ones_pattern_gen #(.W(W), .CW(CW), .RW(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req)
            n_pass++;
        else
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic logic [63:0] model(input int c, input int r);
        logic [63:0] w;
        if (c > 64) return 64'd0;
        w = (c == 64) ? {64{1'b1}} : ((64'd1 << c) - 64'd1);
        for (int i = 0; i < r; i++) w = {w[62:0], w[63]};
        return w;
    endfunction

    // Consumer ready: directed hold while a result is shown, else random or always-ready
    always @(posedge clk) begin
        #2;
        if (hold_req > 0) begin
            bus.out_ready = 1'b0;
            if (bus.out_valid) hold_req--;
        end else if (rand_stall) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end else begin
            bus.out_ready = 1'b1;
        end
    end

    // Monitor
    bit          prev_v = 1'b0;
    bit          ready_next = 1'b0;
    bit          stable_ok, ready_low_ok;
    int          rise_cyc;
    logic [63:0] h_word;
    logic [2:0]  h_flags;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_v     = 1'b0;
            ready_next = 1'b0;
        end else begin
            if (ready_next) begin
                chk("in_ready_after_pop", 64'(bus.in_ready), 64'd1);
                ready_next = 1'b0;
            end
            if (bus.out_valid) begin
                if (!prev_v) begin
                    rise_cyc     = cyc;
                    h_word       = bus.out_word;
                    h_flags      = {bus.out_onehot, bus.out_onecold, bus.out_err};
                    stable_ok    = 1'b1;
                    ready_low_ok = 1'b1;
                end else if (bus.out_word !== h_word ||
                             {bus.out_onehot, bus.out_onecold, bus.out_err} !== h_flags) begin
                    stable_ok = 1'b0;
                end
                if (bus.in_ready) ready_low_ok = 1'b0;
                if (bus.out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("word",     bus.out_word, e.word);
                        chk("onehot",   64'(bus.out_onehot), 64'(e.oh));
                        chk("onecold",  64'(bus.out_onecold), 64'(e.oc));
                        chk("err",      64'(bus.out_err), 64'(e.err));
                        chk("popcount", 64'($countones(bus.out_word)), 64'(e.err ? 0 : e.cnt));
                        chk("latency",  64'(rise_cyc - e.acc), 64'(e.lat));
                        chk("stable",   64'(stable_ok), 64'd1);
                        chk("in_ready_low", 64'(ready_low_ok), 64'd1);
                    end
                    ready_next = 1'b1;
                end
            end
            prev_v = bus.out_valid;
        end
    end

    task automatic issue(input int c, input int r, input int hold, input logic [63:0] word);
        int   n;
        exp_t e;
        hold_req = hold;
        @(posedge clk); #2;
        bus.in_valid = 1'b1;
        bus.in_count = CW'(c);
        bus.in_rot   = RW'(r);
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 64'd1, 64'd0);
        end else begin
            e.word = word;
            e.err  = (c > 64);
            e.oh   = !e.err && (c == 1);
            e.oc   = !e.err && (c == 63);
            e.cnt  = c;
            e.lat  = e.err ? 1 : c + r + 1;
            e.acc  = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk); #2;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"},  64'(bus.in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_out_word"},  bus.out_word, 64'd0);
        chk({tag, "_onehot"},    64'(bus.out_onehot), 64'd0);
        chk({tag, "_onecold"},   64'(bus.out_onecold), 64'd0);
        chk({tag, "_err"},       64'(bus.out_err), 64'd0);
    endtask

    vec_t dir[$] = '{
        '{3,   0,  0, 64'h0000_0000_0000_0007},
        '{1,   63, 0, 64'h8000_0000_0000_0000},
        '{63,  4,  10, 64'hFFFF_FFFF_FFFF_FFF7},
        '{64,  5,  0, 64'hFFFF_FFFF_FFFF_FFFF},
        '{0,   0,  0, 64'h0000_0000_0000_0000},
        '{100, 0,  0, 64'h0000_0000_0000_0000},
        '{127, 17, 0, 64'h0000_0000_0000_0000},
        '{0,   9,  0, 64'h0000_0000_0000_0000},
        '{8,   60, 0, 64'hF000_0000_0000_000F}
    };

    initial begin
        int c, r;
        bus.in_valid  = 1'b0;
        bus.in_count  = '0;
        bus.in_rot    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check_reset_values("reset");

        foreach (dir[i]) begin
            issue(dir[i].c, dir[i].r, dir[i].hold, dir[i].word);
            drain();
        end

        // Abandon a build with a one-cycle reset
        issue(40, 0, 0, model(40, 0));
        repeat (10) @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_reset_values("midbuild_rst");
        sb.delete();
        @(posedge clk); #2;
        rst = 1'b0;
        issue(2, 1, 0, 64'h0000_0000_0000_0006);
        drain();

        rand_stall = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            c = (k % 16 == 7) ? int'($urandom_range(65, 127)) : int'($urandom_range(0, 64));
            r = (k % 8 == 3) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 15));
            issue(c, r, 0, model(c, r));
            drain();
        end
        rand_stall = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=%0d cycles required=completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
